// File: rtl/unary_reduce_sequencer.sv
// Multi-cycle unary AND/OR/XOR reduction of an N*CHUNKS-bit operand over one shared N-bit datapath.
// Optional build macro UNARY_REDUCE_SEQ_EARLY_EXIT_EN: finish as soon as an AND/OR result saturates.
module unary_reduce_sequencer #(
    parameter int unsigned N      = 8,
    parameter int unsigned CHUNKS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [1:0]        op,
    input  logic [N*CHUNKS-1:0] a,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              c,
    output logic              err,
    output logic              busy
);

    localparam int unsigned W    = N * CHUNKS;
    localparam int unsigned IdxW = $clog2(CHUNKS);

    localparam logic [1:0] OpAnd  = 2'b00;
    localparam logic [1:0] OpOr   = 2'b01;
    localparam logic [1:0] OpRsvd = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [1:0]      op_q, op_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            acc_q, acc_d;
    logic            err_q, err_d;

    logic [N-1:0]    chunk;
    logic            acc_nxt;
    logic            last_chunk;
    logic            saturated;

    // The operand register shifts right each RUN edge, so the current chunk is always the low N bits.
    always_comb begin
        chunk = opnd_q[N-1:0];
        case (op_q)
            OpAnd:   acc_nxt = acc_q & (&chunk);
            OpOr:    acc_nxt = acc_q | (|chunk);
            default: acc_nxt = acc_q ^ (^chunk);
        endcase
        last_chunk = (idx_q == IdxW'(CHUNKS - 1));
        saturated  = ((op_q == OpAnd) && !acc_nxt) || ((op_q == OpOr) && acc_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    state_d = (op == OpRsvd) ? StDone : StRun;
                end
            end
            StRun: begin
`ifdef UNARY_REDUCE_SEQ_EARLY_EXIT_EN
                if (last_chunk || saturated) begin
                    state_d = StDone;
                end
`else
                if (last_chunk) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_ready = (state_q == StIdle);
        res_valid   = (state_q == StDone);
        busy        = (state_q != StIdle);
    end

    always_comb begin
        opnd_d = opnd_q;
        op_d   = op_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        err_d  = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    opnd_d = a;
                    op_d   = op;
                    idx_d  = '0;
                    // AND starts from 1; OR, XOR and the reserved op (c=0) start from 0.
                    acc_d  = (op == OpAnd);
                    err_d  = (op == OpRsvd);
                end
            end
            StRun: begin
                opnd_d = opnd_q >> N;
                idx_d  = idx_q + IdxW'(1);
                acc_d  = acc_nxt;
            end
            StDone: begin
                if (res_ready) begin
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= '0;
            op_q   <= '0;
            idx_q  <= '0;
            acc_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            opnd_q <= opnd_d;
            op_q   <= op_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            err_q  <= err_d;
        end
    end

    assign c   = acc_q;
    assign err = err_q;

endmodule
